// File: rtl/message_schedule_pkg.sv
// Shared SHA-256 utilities: word type, round-constant table and small-sigma functions.
package message_schedule_pkg;

  typedef logic [31:0] word_t;

  localparam word_t SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotate_right(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotate_right(x, 7) ^ rotate_right(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotate_right(x, 17) ^ rotate_right(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_schedule.sv
// SHA-256 message schedule: 16-word sliding window emitting W/K per accepted beat.
module message_schedule
  import message_schedule_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [15:0][31:0]  block_in,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [31:0]        wi,
  output logic [31:0]        ki,
  output logic [5:0]         round,
  output logic               w_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  word_t      r_win [16];
  logic [5:0] r_round;
  logic       w_adv;
  logic       w_end;
  logic       w_load;
  word_t      w_new;

  assign w_valid   = (r_state == RUN);
  assign w_last    = w_valid && (r_round == LAST_ROUND);
  assign blk_ready = (r_state == IDLE) | (w_valid & w_last & w_ready);
  assign w_adv     = w_valid & w_ready;
  assign w_end     = w_adv & w_last;
  assign w_load    = blk_valid & blk_ready;
  assign w_new     = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];

  assign wi    = r_win[0];
  assign ki    = SHA256_K[r_round];
  assign round = r_round;

  // A load on the last beat wins over the return to IDLE: zero-bubble block chaining.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load)
      w_state_nxt = RUN;
    else if (w_end)
      w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++)
        r_win[i] <= '0;
      r_round <= '0;
    end else if (w_load) begin
      for (int unsigned i = 0; i < 16; i++)
        r_win[i] <= block_in[15 - i];
      r_round <= '0;
    end else if (w_adv) begin
      for (int unsigned i = 0; i < 15; i++)
        r_win[i] <= r_win[i + 1];
      r_win[15] <= w_new;
      // Round holds at the final index after the block ends so it never wraps.
      if (!w_end)
        r_round <= r_round + 6'd1;
    end
  end

endmodule

// File: tb/tb_message_schedule.sv
// Scoreboard bench for message_schedule: model pushes expected beats, negedge monitor checks.
module tb_message_schedule;

  typedef logic [15:0][31:0] blk_t;
  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  r;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blk_valid;
  logic        blk_ready;
  blk_t        block_in;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] wi;
  logic [31:0] ki;
  logic [5:0]  round;
  logic        w_last;

  int errors = 0;
  int checks = 0;
  int n_pop  = 0;
  int n_exp  = 0;
  exp_t q[$];
  logic [31:0] dut_w [64];
  logic [31:0] dut_k [64];

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  message_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .block_in(block_in), .w_valid(w_valid), .w_ready(w_ready), .wi(wi), .ki(ki),
    .round(round), .w_last(w_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic void push_block(input blk_t b);
    logic [31:0] ws [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ws[t] = b[15 - t];
      else ws[t] = (ror(ws[t-2], 17) ^ ror(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
                 + (ror(ws[t-15], 7) ^ ror(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
      e.w = ws[t]; e.k = KT[t]; e.r = 6'(t); e.last = (t == 63);
      q.push_back(e);
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare presented beat against the queue head, pop on handshake, push on acceptance.
  always @(negedge clk) begin
    logic exp_v, exp_r;
    if (rst_n) begin
      exp_v = (q.size() != 0);
      exp_r = (q.size() == 0) || (q.size() == 1 && w_ready);
      chk("w_valid", {31'b0, w_valid}, {31'b0, exp_v});
      chk("blk_ready", {31'b0, blk_ready}, {31'b0, exp_r});
      if (w_valid && exp_v) begin
        chk("wi", wi, q[0].w);
        chk("ki", ki, q[0].k);
        chk("round", {26'b0, round}, {26'b0, q[0].r});
        chk("w_last", {31'b0, w_last}, {31'b0, q[0].last});
        if (w_ready) begin
          dut_w[round] = wi;
          dut_k[round] = ki;
          void'(q.pop_front());
          n_pop++;
        end
      end
      if (blk_valid && exp_r) push_block(block_in);
    end
  end

  task automatic send_block(input blk_t b, input bit drop);
    int n;
    block_in  = b;
    blk_valid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (blk_ready) break;
    end
    if (n == 3000) begin
      errors++;
      $display("FAIL send_block: blk_ready timeout got 0 expected 1");
    end
    @(posedge clk); #1;
    if (drop) blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !w_valid) break;
    end
    if (n == 5000) begin
      errors++;
      $display("FAIL wait_idle: timeout queue=%0d expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_round(input int r);
    int n;
    for (n = 0; n < 500; n++) begin
      if (w_valid && round == 6'(r)) break;
      @(posedge clk); #1;
    end
    if (n == 500) begin
      errors++;
      $display("FAIL wait_round: round %0d not reached, got %0d", r, round);
    end
  endtask

  blk_t abc, blk_a, blk_b, rb;
  bit   rdone;

  initial begin
    abc = '0;
    abc[15] = 32'h61626380;
    abc[0]  = 32'h00000018;
    for (int i = 0; i < 16; i++) begin
      blk_a[i] = 32'h01010101 * (i + 1);
      blk_b[i] = ~(32'h10203040 + 32'(i));
    end
    rst_n = 1'b0; blk_valid = 1'b0; w_ready = 1'b1; block_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_w_valid", {31'b0, w_valid}, 32'd0);
    chk("rst_w_last", {31'b0, w_last}, 32'd0);
    chk("rst_blk_ready", {31'b0, blk_ready}, 32'd1);
    chk("rst_round", {26'b0, round}, 32'd0);
    chk("rst_wi", wi, 32'd0);
    chk("rst_ki", ki, 32'h428A2F98);
    @(posedge clk); #1;

    // "abc" block, no stall
    send_block(abc, 1'b1); n_exp += 64;
    wait_idle();
    chk("abc_W0", dut_w[0], 32'h61626380);
    chk("abc_W15", dut_w[15], 32'h00000018);
    chk("abc_W16", dut_w[16], 32'h61626380);
    chk("abc_W17", dut_w[17], 32'h000F0000);
    chk("abc_K0", dut_k[0], 32'h428A2F98);
    chk("abc_K63", dut_k[63], 32'hC67178F2);

    // backpressure at round 20
    send_block(abc, 1'b1); n_exp += 64;
    wait_round(20);
    w_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 w_ready = 1'b1;
    wait_idle();

    // back-to-back
    send_block(blk_a, 1'b0);
    send_block(blk_b, 1'b1); n_exp += 128;
    wait_idle();

    // busy load ignored
    send_block(abc, 1'b1); n_exp += 64;
    wait_round(10);
    blk_valid = 1'b1; block_in = blk_b;
    @(posedge clk); #1 blk_valid = 1'b0;
    wait_idle();

    // reset mid-run
    send_block(abc, 1'b1); n_exp += 30;
    wait_round(30);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_w_valid", {31'b0, w_valid}, 32'd0);
    chk("mrst_round", {26'b0, round}, 32'd0);
    chk("mrst_blk_ready", {31'b0, blk_ready}, 32'd1);
    @(posedge clk); #1;
    send_block(abc, 1'b1); n_exp += 64;
    wait_idle();

    // random blocks with random w_ready
    rdone = 1'b0;
    fork
      begin
        for (int b = 0; b < 200; b++) begin
          for (int i = 0; i < 16; i++) rb[i] = $urandom;
          send_block(rb, 1'b1);
          n_exp += 64;
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          w_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    w_ready = 1'b1;
    wait_idle();
    chk("word_count", 32'(n_pop), 32'(n_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
